config_menu: RTL and testbench

- Parametrised successor to the fixed CHIP-8 configuration state: a button-driven settings menu holding emulator speed, program selection, display palette and audio settings.
- Generates the CHIP-8 instruction-rate tick enable.
- Runs a request/acknowledge handshake with the program loader when a new ROM is confirmed.
- Sits between the debounced button front-end and the CHIP-8 core, the loader, the video path and the audio path.

---
 rtl/config_pkg.sv | 47 ++++
 rtl/config_menu_if.sv | 24 ++
 rtl/tick_divider.sv | 48 ++++
 rtl/config_menu.sv | 168 ++++++++++++++++
 tb/tb_config_menu.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// config_pkg: shared types and constants for the CHIP-8 settings menu.
//   field_t       cursor fields in menu order
//   FIELD_COUNT   number of cursor fields
//   color_pair_t  {light, dark} RGB888 pair
//   PALETTE       selectable colour pairs
//   load_state_t  loader handshake states
//   wrap_step     +/-1 step that wraps within 0..lim-1
package config_pkg;

  typedef enum logic [2:0] {
    F_SPEED   = 3'd0,
    F_PROG    = 3'd1,
    F_PALETTE = 3'd2,
    F_TIMBRE  = 3'd3,
    F_PITCH   = 3'd4,
    F_VOL     = 3'd5
  } field_t;

  localparam int unsigned FIELD_COUNT = 6;

  typedef struct packed {
    logic [23:0] light;
    logic [23:0] dark;
  } color_pair_t;

  localparam int PALETTE_MAX = 4;

  localparam color_pair_t PALETTE [PALETTE_MAX] = '{
    {24'hFFFFFF, 24'h000000},
    {24'h9BBC0F, 24'h0F380F},
    {24'hE0F8D0, 24'h081820},
    {24'hFFB000, 24'h1A0E00}
  };

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } load_state_t;

  function automatic int unsigned wrap_step(input int unsigned v,
                                            input int unsigned lim,
                                            input logic        up);
    if (up) return (v >= lim - 1) ? 0 : v + 1;
    else    return (v == 0) ? lim - 1 : v - 1;
  endfunction

endpackage

// File: rtl/config_menu_if.sv
// config_menu_if: program-loader handshake.
//   prog_sel_out  program index committed for loading
//   load_req_out  load request level, held until acknowledged
//   load_ack_in   loader done
// master = menu side, slave = loader side.
interface config_menu_if #(
  parameter int PROG_W = 4
);
  logic [PROG_W-1:0] prog_sel_out;
  logic              load_req_out;
  logic              load_ack_in;

  modport master (
    output prog_sel_out,
    output load_req_out,
    input  load_ack_in
  );

  modport slave (
    input  prog_sel_out,
    input  load_req_out,
    output load_ack_in
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: CHIP-8 instruction-rate enable.
//   clk_in, rst_n_in  clock, async active-low reset
//   i_speed           speed index k, rate = RATE_BASE << k
//   i_clear           zero the counter, suppress the tick this cycle
//   i_hold            freeze the counter, suppress the tick
//   o_tick            one-cycle enable when the counter reaches period-1
module tick_divider #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int RATE_BASE  = 60,
  parameter int NUM_SPEEDS = 8,
  localparam int SPD_W     = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [SPD_W-1:0] i_speed,
  input  logic             i_clear,
  input  logic             i_hold,
  output logic             o_tick
);

  localparam int CNT_W = $clog2(CLK_FREQ / RATE_BASE + 1);

  logic [CNT_W-1:0] w_last [NUM_SPEEDS];
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  // Terminal counts are elaboration-time constants; a rate above CLK_FREQ
  // saturates to a tick every cycle instead of an unusable period of 0.
  for (genvar k = 0; k < NUM_SPEEDS; k++) begin : g_last
    localparam int PERIOD_RAW = CLK_FREQ / (RATE_BASE << k);
    localparam int PERIOD     = (PERIOD_RAW < 1) ? 1 : PERIOD_RAW;
    assign w_last[k] = CNT_W'(PERIOD - 1);
  end

  assign w_at_last = (r_cnt >= w_last[i_speed]);
  assign o_tick    = w_at_last & ~i_clear & ~i_hold;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/config_menu.sv
// config_menu: button-driven CHIP-8 settings menu.
//   clk_in, rst_n_in     clock, async active-low reset
//   btn_*_in             one-cycle button pulses (left/right move, up/down edit,
//                        sel confirms the pending program)
//   ldr_if               loader request/acknowledge handshake (master side)
//   chip8_tick_out       instruction-rate enable
//   field_out            cursor field
//   prog_pending_out     program highlighted in the menu
//   light/dark_color_out palette colours, RGB888
//   timbre/pitch/vol_out audio settings
module config_menu
  import config_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int RATE_BASE    = 60,
  parameter int NUM_SPEEDS   = 8,
  parameter int NUM_PROGS    = 16,
  parameter int NUM_PALETTES = 4,
  parameter int VOL_W        = 3,
  localparam int PROG_W      = $clog2(NUM_PROGS)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              btn_left_in,
  input  logic              btn_right_in,
  input  logic              btn_up_in,
  input  logic              btn_down_in,
  input  logic              btn_sel_in,
  config_menu_if.master     ldr_if,
  output logic              chip8_tick_out,
  output logic [2:0]        field_out,
  output logic [PROG_W-1:0] prog_pending_out,
  output logic [23:0]       light_color_out,
  output logic [23:0]       dark_color_out,
  output logic [1:0]        timbre_out,
  output logic [3:0]        pitch_out,
  output logic [VOL_W-1:0]  vol_out
);

  localparam int SPD_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
  localparam int PAL_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam logic [SPD_W-1:0] SPEED_RST = SPD_W'(3);
  localparam logic [3:0]       PITCH_RST = 4'd8;
  localparam logic [VOL_W-1:0] VOL_RST   = VOL_W'(1 << (VOL_W - 1));

  field_t            r_field,  w_field_nxt;
  logic [SPD_W-1:0]  r_speed,  w_speed_nxt;
  logic [PROG_W-1:0] r_pend,   w_pend_nxt;
  logic [PROG_W-1:0] r_sel;
  logic [PAL_W-1:0]  r_pal,    w_pal_nxt;
  logic [1:0]        r_timbre, w_timbre_nxt;
  logic [3:0]        r_pitch,  w_pitch_nxt;
  logic [VOL_W-1:0]  r_vol,    w_vol_nxt;
  load_state_t       r_state,  w_state_nxt;

  logic        w_up, w_dn, w_edit, w_right, w_move;
  logic        w_busy, w_accept, w_speed_clr, w_tick;
  color_pair_t w_colors;

  // Opposing buttons pressed together cancel out.
  assign w_up    = btn_up_in & ~btn_down_in;
  assign w_dn    = btn_down_in & ~btn_up_in;
  assign w_edit  = w_up | w_dn;
  assign w_right = btn_right_in & ~btn_left_in;
  assign w_move  = btn_right_in ^ btn_left_in;

  assign w_speed_clr = w_edit && (r_field == F_SPEED);

  // ---------------- load FSM: state register ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // ---------------- load FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (btn_sel_in && !ldr_if.load_ack_in) w_state_nxt = REQ;
      REQ:     if (ldr_if.load_ack_in)                w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- load FSM: outputs ----------------
  always_comb begin
    w_busy   = (r_state == REQ);
    w_accept = (r_state == IDLE) && btn_sel_in && !ldr_if.load_ack_in;
  end

  // ---------------- menu edits ----------------
  // Edits act on the field selected before any same-cycle cursor move.
  always_comb begin
    w_field_nxt  = r_field;
    w_speed_nxt  = r_speed;
    w_pend_nxt   = r_pend;
    w_pal_nxt    = r_pal;
    w_timbre_nxt = r_timbre;
    w_pitch_nxt  = r_pitch;
    w_vol_nxt    = r_vol;

    if (w_move)
      w_field_nxt = field_t'(3'(wrap_step(32'(r_field), FIELD_COUNT, w_right)));

    if (w_edit) begin
      unique case (r_field)
        F_SPEED:   w_speed_nxt  = SPD_W'(wrap_step(32'(r_speed), NUM_SPEEDS, w_up));
        F_PROG:    if (!w_busy)
                     w_pend_nxt = PROG_W'(wrap_step(32'(r_pend), NUM_PROGS, w_up));
        F_PALETTE: w_pal_nxt    = PAL_W'(wrap_step(32'(r_pal), NUM_PALETTES, w_up));
        F_TIMBRE:  w_timbre_nxt = 2'(wrap_step(32'(r_timbre), 4, w_up));
        F_PITCH:   w_pitch_nxt  = 4'(wrap_step(32'(r_pitch), 16, w_up));
        F_VOL:     w_vol_nxt    = VOL_W'(wrap_step(32'(r_vol), 1 << VOL_W, w_up));
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_field  <= F_SPEED;
      r_speed  <= SPEED_RST;
      r_pend   <= '0;
      r_sel    <= '0;
      r_pal    <= '0;
      r_timbre <= '0;
      r_pitch  <= PITCH_RST;
      r_vol    <= VOL_RST;
    end else begin
      r_field  <= w_field_nxt;
      r_speed  <= w_speed_nxt;
      r_pend   <= w_pend_nxt;
      r_pal    <= w_pal_nxt;
      r_timbre <= w_timbre_nxt;
      r_pitch  <= w_pitch_nxt;
      r_vol    <= w_vol_nxt;
      if (w_accept) r_sel <= r_pend;
    end
  end

  // ---------------- instruction tick ----------------
  tick_divider #(
    .CLK_FREQ   (CLK_FREQ),
    .RATE_BASE  (RATE_BASE),
    .NUM_SPEEDS (NUM_SPEEDS)
  ) u_div (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_speed  (r_speed),
    .i_clear  (w_speed_clr),
    .i_hold   (w_busy),
    .o_tick   (w_tick)
  );

  assign w_colors = PALETTE[r_pal];

  assign chip8_tick_out      = w_tick;
  assign field_out           = r_field;
  assign prog_pending_out    = r_pend;
  assign ldr_if.prog_sel_out = r_sel;
  assign ldr_if.load_req_out = w_busy;
  assign light_color_out     = w_colors.light;
  assign dark_color_out      = w_colors.dark;
  assign timbre_out          = r_timbre;
  assign pitch_out           = r_pitch;
  assign vol_out             = r_vol;

endmodule

// File: tb/tb_config_menu.sv
module tb_config_menu;
  import config_pkg::*;

  localparam int CLK_FREQ     = 960;
  localparam int RATE_BASE    = 60;
  localparam int NUM_SPEEDS   = 5;
  localparam int NUM_PROGS    = 16;
  localparam int NUM_PALETTES = 4;
  localparam int VOL_W        = 3;
  localparam int PROG_W       = $clog2(NUM_PROGS);

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_L    = 5'b10000;
  localparam logic [4:0] B_R    = 5'b01000;
  localparam logic [4:0] B_U    = 5'b00100;
  localparam logic [4:0] B_D    = 5'b00010;
  localparam logic [4:0] B_S    = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, bs = 1'b0;
  logic              tick;
  logic [2:0]        field;
  logic [PROG_W-1:0] pend;
  logic [23:0]       light, dark;
  logic [1:0]        timbre;
  logic [3:0]        pitch;
  logic [VOL_W-1:0]  vol;

  config_menu_if #(.PROG_W(PROG_W)) ldr_if ();

  config_menu #(
    .CLK_FREQ     (CLK_FREQ),
    .RATE_BASE    (RATE_BASE),
    .NUM_SPEEDS   (NUM_SPEEDS),
    .NUM_PROGS    (NUM_PROGS),
    .NUM_PALETTES (NUM_PALETTES),
    .VOL_W        (VOL_W)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .btn_left_in      (bl),
    .btn_right_in     (br),
    .btn_up_in        (bu),
    .btn_down_in      (bd),
    .btn_sel_in       (bs),
    .ldr_if           (ldr_if),
    .chip8_tick_out   (tick),
    .field_out        (field),
    .prog_pending_out (pend),
    .light_color_out  (light),
    .dark_color_out   (dark),
    .timbre_out       (timbre),
    .pitch_out        (pitch),
    .vol_out          (vol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Settings held as one value per field index, edited modulo the field size.
  int unsigned bound [6];
  int unsigned m_val [6];
  int unsigned m_field, m_sel, m_cnt;
  bit          m_req;
  logic        last_tick;

  function automatic int unsigned period(input int unsigned k);
    return CLK_FREQ / (RATE_BASE << k);
  endfunction

  task automatic model_reset();
    m_field = 0;
    m_val   = '{3, 0, 0, 0, 8, 1 << (VOL_W - 1)};
    m_sel   = 0;
    m_req   = 0;
    m_cnt   = 0;
  endtask

  function automatic bit model_tick(input logic [4:0] b);
    bit spd_edit;
    spd_edit = (m_field == 0) && (b[2] != b[1]);
    return !m_req && !spd_edit && (m_cnt == period(m_val[0]) - 1);
  endfunction

  task automatic model_step(input logic [4:0] b, input logic ack);
    bit t, old_req, up, dn;
    t       = model_tick(b);
    old_req = m_req;
    up      = b[2] && !b[1];
    dn      = b[1] && !b[2];
    if ((m_field == 0) && (up || dn)) m_cnt = 0;
    else if (!old_req)                m_cnt = t ? 0 : m_cnt + 1;
    if (old_req) begin
      if (ack) m_req = 0;
    end else if (b[0] && !ack) begin
      m_sel = m_val[1];
      m_req = 1;
    end
    if ((up || dn) && !(m_field == 1 && old_req))
      m_val[m_field] = (m_val[m_field] + (up ? 1 : bound[m_field] - 1)) % bound[m_field];
    if (b[4] != b[3])
      m_field = (m_field + (b[3] ? 1 : 5)) % 6;
  endtask

  task automatic check_all();
    check("field",   field, m_field);
    check("pending", pend, m_val[1]);
    check("prog_sel", ldr_if.prog_sel_out, m_sel);
    check("load_req", ldr_if.load_req_out, m_req);
    check("light",   light, PALETTE[m_val[2]].light);
    check("dark",    dark, PALETTE[m_val[2]].dark);
    check("timbre",  timbre, m_val[3]);
    check("pitch",   pitch, m_val[4]);
    check("vol",     vol, m_val[5]);
  endtask

  // Called at a falling edge: drive, check tick, clock, check registers.
  task automatic cycle(input logic [4:0] b, input logic ack);
    {bl, br, bu, bd, bs} = b;
    ldr_if.load_ack_in   = ack;
    #1;
    last_tick = tick;
    check("tick", tick, model_tick(b));
    @(posedge clk);
    model_step(b, ack);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [4:0] btn;
    logic       ack;
    logic       tick;
    int         field;
    int         pend;
    int         sel;
    logic       req;
    int         pitch;
    int         vol;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] b;
    logic       a;

    bound = '{NUM_SPEEDS, NUM_PROGS, NUM_PALETTES, 4, 16, 1 << VOL_W};
    ldr_if.load_ack_in = 1'b0;

    //            btn    ack   tick  fld pnd sel req   pit vol
    vecs.push_back('{B_NONE, 1'b0, 1'b0, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_NONE, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_NONE, 1'b0, 1'b0, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_U,    1'b0, 1'b0, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_NONE, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_NONE, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 1, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 2, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 3, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 4, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_R,    1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_L,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 4});
    vecs.push_back('{B_D,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 3});
    vecs.push_back('{B_D,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 2});
    vecs.push_back('{B_D,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 1});
    vecs.push_back('{B_D,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 0});
    vecs.push_back('{B_D,    1'b0, 1'b1, 5, 0, 0, 1'b0, 8, 7});
    vecs.push_back('{B_L,    1'b0, 1'b1, 4, 0, 0, 1'b0, 8, 7});
    vecs.push_back('{B_L,    1'b0, 1'b1, 3, 0, 0, 1'b0, 8, 7});
    vecs.push_back('{B_L,    1'b0, 1'b1, 2, 0, 0, 1'b0, 8, 7});
    vecs.push_back('{B_L,    1'b0, 1'b1, 1, 0, 0, 1'b0, 8, 7});
    vecs.push_back('{B_U,    1'b0, 1'b1, 1, 1, 0, 1'b0, 8, 7});
    vecs.push_back('{B_U,    1'b0, 1'b1, 1, 2, 0, 1'b0, 8, 7});
    vecs.push_back('{B_U,    1'b0, 1'b1, 1, 3, 0, 1'b0, 8, 7});
    vecs.push_back('{B_S,    1'b0, 1'b1, 1, 3, 3, 1'b1, 8, 7});
    vecs.push_back('{B_U,    1'b0, 1'b0, 1, 3, 3, 1'b1, 8, 7});
    vecs.push_back('{B_NONE, 1'b0, 1'b0, 1, 3, 3, 1'b1, 8, 7});
    vecs.push_back('{B_NONE, 1'b1, 1'b0, 1, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_NONE, 1'b0, 1'b1, 1, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_U|B_D, 1'b0, 1'b1, 1, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_L|B_R, 1'b0, 1'b1, 1, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_R,    1'b0, 1'b1, 2, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_R,    1'b0, 1'b1, 3, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_R,    1'b0, 1'b1, 4, 3, 3, 1'b0, 8, 7});
    vecs.push_back('{B_U|B_R, 1'b0, 1'b1, 5, 3, 3, 1'b0, 9, 7});
    vecs.push_back('{B_NONE, 1'b1, 1'b1, 5, 3, 3, 1'b0, 9, 7});
    vecs.push_back('{B_S,    1'b1, 1'b1, 5, 3, 3, 1'b0, 9, 7});

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tick",  tick, 1'b0);
    check("rst_field", field, 0);
    check("rst_pitch", pitch, 8);
    check("rst_vol",   vol, 4);
    check("rst_light", light, 24'hFFFFFF);
    check("rst_dark",  dark, 24'h000000);
    check("rst_req",   ldr_if.load_req_out, 1'b0);
    rst_n = 1'b1;
    model_reset();

    // Directed vectors.
    foreach (vecs[i]) begin
      cycle(vecs[i].btn, vecs[i].ack);
      check("vec_tick",  last_tick, vecs[i].tick);
      check("vec_field", field, vecs[i].field);
      check("vec_pend",  pend, vecs[i].pend);
      check("vec_sel",   ldr_if.prog_sel_out, vecs[i].sel);
      check("vec_req",   ldr_if.load_req_out, vecs[i].req);
      check("vec_pitch", pitch, vecs[i].pitch);
      check("vec_vol",   vol, vecs[i].vol);
    end

    // Palette 1 colours.
    repeat (3) cycle(B_L, 1'b0);
    cycle(B_U, 1'b0);
    check("pal1_light", light, 24'h9BBC0F);
    check("pal1_dark",  dark, 24'h0F380F);

    // Asynchronous reset in the middle of a load request.
    cycle(B_S, 1'b0);
    check("req_before_rst", ldr_if.load_req_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req",   ldr_if.load_req_out, 1'b0);
    check("midrst_sel",   ldr_if.prog_sel_out, 0);
    check("midrst_field", field, 0);
    check("midrst_pend",  pend, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      b = '0;
      for (int j = 0; j < 5; j++)
        if ($urandom_range(7) == 0) b[j] = 1'b1;
      a = m_req ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      cycle(b, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
